// File: rtl/mem_store_unit.sv
// mem_store_unit: store queue, MMIO decode and byte-enabled writes to the CPU
// BRAM, the buffer BRAM or the output register.
// Optional feature macro: STORE_FAULT_EN. It adds the st_fault pulse and the
// fault_addr capture for dropped stores. Without it both outputs are tied to 0.
// Lane k of a BRAM word is din[8k+7:8k], which holds byte address offset k.
// A register value is big-endian, so a word store byte-swaps into the lanes.
module mem_store_unit #(
  parameter int          DEPTH            = 4,
  parameter int          ADDR_W           = 21,
  parameter logic [31:0] CPU_BRAM_START   = 32'h0000_0000,
  parameter logic [31:0] CPU_BRAM_END     = 32'h007F_FF00,
  parameter logic [31:0] BUF_BRAM_START   = 32'h0100_0000,
  parameter logic [31:0] BUF_BRAM_END     = 32'h013F_FF00,
  parameter logic [31:0] WRITE_REG_OUTPUT = 32'h0200_0100
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              st_valid,
  output logic              st_ready,
  input  logic [31:0]       st_addr,
  input  logic [31:0]       st_data,
  input  logic [1:0]        st_size,
  input  logic              buf_wr_ready,
  output logic [3:0]        cpu_we,
  output logic [ADDR_W-1:0] cpu_addr,
  output logic [31:0]       cpu_din,
  output logic [3:0]        buf_we,
  output logic [ADDR_W-1:0] buf_addr,
  output logic [31:0]       buf_din,
  output logic [31:0]       out_reg,
  output logic              st_empty,
  output logic              st_fault,
  output logic [31:0]       fault_addr
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  size;
  } st_req_t;

  st_req_t           q_mem [DEPTH];
  logic [PW-1:0]     rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]     count_q, count_d;
  logic              busy_q;
  logic [3:0]        cpu_we_q, buf_we_q;
  logic [ADDR_W-1:0] cpu_addr_q, buf_addr_q;
  logic [31:0]       cpu_din_q, buf_din_q, out_reg_q;

  st_req_t     in_req, head;
  logic        push, head_vld, go, enq, deq;
  logic [1:0]  off;
  logic [3:0]  lane_we;
  logic [31:0] lane_din;
  logic        align_ok, hit_cpu, hit_buf, hit_out;
  logic        tgt_cpu, tgt_buf, tgt_out;
  logic [31:0] cpu_off, buf_off;

  assign in_req   = '{addr: st_addr, data: st_data, size: st_size};
  assign st_ready = (count_q != CW'(DEPTH));
  assign push     = st_valid && st_ready && !reset;
  // Nothing queued, nothing just written, and nothing arriving this cycle.
  assign st_empty = (count_q == '0) && !busy_q && !push;

  // Head selection, lane placement, region decode and pop decision.
  // An empty queue lets the incoming request act as head, which gives the
  // one-cycle push-to-strobe latency.
  always_comb begin
    head     = (count_q != '0) ? q_mem[rd_ptr_q] : in_req;
    head_vld = (count_q != '0) || push;
    off      = head.addr[1:0];
    lane_we  = 4'b0000;
    lane_din = 32'h0;
    align_ok = 1'b0;
    case (head.size)
      2'b00: begin
        align_ok = 1'b1;
        lane_we  = 4'b0001 << off;
        lane_din = {24'h0, head.data[7:0]} << {off, 3'b000};
      end
      2'b01: if (!off[0]) begin
        align_ok = 1'b1;
        if (off[1]) begin
          lane_we  = 4'b1100;
          lane_din = {head.data[7:0], head.data[15:8], 16'h0};
        end else begin
          lane_we  = 4'b0011;
          lane_din = {16'h0, head.data[7:0], head.data[15:8]};
        end
      end
      2'b10: if (off == 2'b00) begin
        align_ok = 1'b1;
        lane_we  = 4'b1111;
        lane_din = {head.data[7:0], head.data[15:8], head.data[23:16], head.data[31:24]};
      end
      default: ;
    endcase
    // Single unsigned compare on the offset covers both region bounds.
    cpu_off = head.addr - CPU_BRAM_START;
    buf_off = head.addr - BUF_BRAM_START;
    hit_cpu = cpu_off <= (CPU_BRAM_END - CPU_BRAM_START);
    hit_buf = buf_off <= (BUF_BRAM_END - BUF_BRAM_START);
    hit_out = (head.addr & ~32'h3) == WRITE_REG_OUTPUT;
    tgt_cpu = align_ok && hit_cpu;
    tgt_buf = align_ok && !hit_cpu && hit_buf;
    tgt_out = align_ok && !hit_cpu && !hit_buf && hit_out;
    // Only a buffer write without a grant stalls the head; drops always pop.
    go      = head_vld && !(tgt_buf && !buf_wr_ready);
    enq     = push && !((count_q == '0) && go);
    deq     = go && (count_q != '0);
    count_d = count_q + CW'(enq) - CW'(deq);
  end

  // Queue storage; pointers guard validity so no reset is needed here.
  always_ff @(posedge clk) begin
    if (enq) q_mem[wr_ptr_q] <= in_req;
  end

  // Queue pointers, registered write strobes and the output register.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      busy_q     <= 1'b0;
      cpu_we_q   <= 4'b0;
      cpu_addr_q <= '0;
      cpu_din_q  <= '0;
      buf_we_q   <= 4'b0;
      buf_addr_q <= '0;
      buf_din_q  <= '0;
      out_reg_q  <= '0;
    end else begin
      if (enq) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (deq) rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q  <= count_d;
      busy_q   <= go;
      cpu_we_q <= (go && tgt_cpu) ? lane_we : 4'b0;
      buf_we_q <= (go && tgt_buf) ? lane_we : 4'b0;
      if (go && tgt_cpu) begin
        cpu_addr_q <= cpu_off[ADDR_W+1:2];
        cpu_din_q  <= lane_din;
      end
      if (go && tgt_buf) begin
        buf_addr_q <= buf_off[ADDR_W+1:2];
        buf_din_q  <= lane_din;
      end
      // Lane k maps to register byte 31-8k so a word store reads back unchanged.
      for (int k = 0; k < 4; k++)
        if (go && tgt_out && lane_we[k])
          out_reg_q[31-8*k -: 8] <= lane_din[8*k +: 8];
    end
  end

  assign cpu_we   = cpu_we_q;
  assign cpu_addr = cpu_addr_q;
  assign cpu_din  = cpu_din_q;
  assign buf_we   = buf_we_q;
  assign buf_addr = buf_addr_q;
  assign buf_din  = buf_din_q;
  assign out_reg  = out_reg_q;

`ifdef STORE_FAULT_EN
  logic        st_fault_q;
  logic [31:0] fault_addr_q;

  // Pulse and capture the address when a popped store targets nothing.
  always_ff @(posedge clk) begin
    if (reset) begin
      st_fault_q   <= 1'b0;
      fault_addr_q <= '0;
    end else begin
      st_fault_q <= go && !(tgt_cpu || tgt_buf || tgt_out);
      if (go && !(tgt_cpu || tgt_buf || tgt_out)) fault_addr_q <= head.addr;
    end
  end

  assign st_fault   = st_fault_q;
  assign fault_addr = fault_addr_q;
`else
  assign st_fault   = 1'b0;
  assign fault_addr = 32'h0;
`endif

endmodule

// File: tb/tb_mem_store_unit.sv
// Directed bench for mem_store_unit: a vector table of single stores, then
// hand sequences for buffer backpressure and reset with queued stores.
module tb_mem_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        st_valid;
  logic        st_ready;
  logic [31:0] st_addr, st_data;
  logic [1:0]  st_size;
  logic        buf_wr_ready;
  logic [3:0]  cpu_we, buf_we;
  logic [20:0] cpu_addr, buf_addr;
  logic [31:0] cpu_din, buf_din, out_reg, fault_addr;
  logic        st_empty, st_fault;

  int errors = 0;
  int checks = 0;

  mem_store_unit dut (
    .clk(clk), .reset(reset), .st_valid(st_valid), .st_ready(st_ready),
    .st_addr(st_addr), .st_data(st_data), .st_size(st_size),
    .buf_wr_ready(buf_wr_ready),
    .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
    .buf_we(buf_we), .buf_addr(buf_addr), .buf_din(buf_din),
    .out_reg(out_reg), .st_empty(st_empty), .st_fault(st_fault),
    .fault_addr(fault_addr)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  sz;
    logic [3:0]  cwe;
    logic [20:0] caddr;
    logic [31:0] cdin;
    logic [3:0]  bwe;
    logic [20:0] baddr;
    logic [31:0] bdin;
    logic [31:0] oreg;
    bit          drop;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic add(input string nm, input logic [31:0] a, input logic [31:0] d,
                     input logic [1:0] sz, input logic [3:0] cwe, input logic [20:0] caddr,
                     input logic [31:0] cdin, input logic [3:0] bwe, input logic [20:0] baddr,
                     input logic [31:0] bdin, input logic [31:0] oreg, input bit drop);
    vec_t v;
    v.name = nm; v.addr = a; v.data = d; v.sz = sz;
    v.cwe = cwe; v.caddr = caddr; v.cdin = cdin;
    v.bwe = bwe; v.baddr = baddr; v.bdin = bdin;
    v.oreg = oreg; v.drop = drop;
    vq.push_back(v);
  endtask

  task automatic push_one(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
    @(negedge clk);
    st_valid = 1'b1; st_addr = a; st_data = d; st_size = sz;
    @(posedge clk);
    #1;
    st_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bit          fault_en;
    logic [31:0] exp_faddr;
    int          acc;

`ifdef STORE_FAULT_EN
    fault_en = 1'b1;
`else
    fault_en = 1'b0;
`endif

    //   name        addr          data          sz    cwe     caddr       cdin          bwe     baddr      bdin          oreg          drop
    add("w_cpu",   32'h0000_0010, 32'h1122_3344, 2'd2, 4'hF, 21'h4,      32'h4433_2211, 4'h0, 21'h0,     32'h0,        32'h0,        0);
    add("b_buf",   32'h0100_0003, 32'h0000_00AB, 2'd0, 4'h0, 21'h0,      32'h0,         4'h8, 21'h0,     32'hAB00_0000, 32'h0,        0);
    add("h_buf",   32'h0100_0002, 32'h0000_BEEF, 2'd1, 4'h0, 21'h0,      32'h0,         4'hC, 21'h0,     32'hEFBE_0000, 32'h0,        0);
    add("b_out",   32'h0200_0102, 32'h0000_005A, 2'd0, 4'h0, 21'h0,      32'h0,         4'h0, 21'h0,     32'h0,        32'h0000_5A00, 0);
    add("w_out",   32'h0200_0100, 32'hCAFE_BABE, 2'd2, 4'h0, 21'h0,      32'h0,         4'h0, 21'h0,     32'h0,        32'hCAFE_BABE, 0);
    add("h_cpuend",32'h007F_FF00, 32'h0000_1234, 2'd1, 4'h3, 21'h1FFFC0, 32'h0000_3412, 4'h0, 21'h0,     32'h0,        32'hCAFE_BABE, 0);
    add("b_pastend",32'h007F_FF01,32'h0000_0077, 2'd0, 4'h0, 21'h0,      32'h0,         4'h0, 21'h0,     32'h0,        32'hCAFE_BABE, 1);
    add("h_odd",   32'h0000_0001, 32'h0000_1111, 2'd1, 4'h0, 21'h0,      32'h0,         4'h0, 21'h0,     32'h0,        32'hCAFE_BABE, 1);
    add("w_nomap", 32'h0300_0000, 32'h2222_2222, 2'd2, 4'h0, 21'h0,      32'h0,         4'h0, 21'h0,     32'h0,        32'hCAFE_BABE, 1);
    add("sz_bad",  32'h0000_0020, 32'h3333_3333, 2'd3, 4'h0, 21'h0,      32'h0,         4'h0, 21'h0,     32'h0,        32'hCAFE_BABE, 1);
    add("w_bufend",32'h013F_FF00, 32'hDEAD_BEEF, 2'd2, 4'h0, 21'h0,      32'h0,         4'hF, 21'hFFFC0, 32'hEFBE_ADDE, 32'hCAFE_BABE, 0);
    add("b_outnxt",32'h0200_0104, 32'h0000_0099, 2'd0, 4'h0, 21'h0,      32'h0,         4'h0, 21'h0,     32'h0,        32'hCAFE_BABE, 1);
    add("h_out",   32'h0200_0100, 32'h0000_A1B2, 2'd1, 4'h0, 21'h0,      32'h0,         4'h0, 21'h0,     32'h0,        32'hA1B2_BABE, 0);
    add("b_cpu7",  32'h0000_0007, 32'h0000_00C3, 2'd0, 4'h8, 21'h1,      32'hC300_0000, 4'h0, 21'h0,     32'h0,        32'hA1B2_BABE, 0);

    reset = 1'b1; st_valid = 1'b0; st_addr = '0; st_data = '0; st_size = '0;
    buf_wr_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cpu_we", {28'h0, cpu_we}, 32'h0);
    chk("rst_buf_we", {28'h0, buf_we}, 32'h0);
    chk("rst_cpu_addr", {11'h0, cpu_addr}, 32'h0);
    chk("rst_cpu_din", cpu_din, 32'h0);
    chk("rst_out_reg", out_reg, 32'h0);
    chk("rst_ready", {31'h0, st_ready}, 32'h1);
    chk("rst_empty", {31'h0, st_empty}, 32'h1);
    chk("rst_fault", {31'h0, st_fault}, 32'h0);
    chk("rst_fault_addr", fault_addr, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // Each store is presented for one cycle; its strobe is expected right after.
    foreach (vq[i]) begin
      push_one(vq[i].addr, vq[i].data, vq[i].sz);
      chk({vq[i].name, "_cpu_we"}, {28'h0, cpu_we}, {28'h0, vq[i].cwe});
      if (vq[i].cwe != 4'h0) begin
        chk({vq[i].name, "_cpu_addr"}, {11'h0, cpu_addr}, {11'h0, vq[i].caddr});
        chk({vq[i].name, "_cpu_din"}, cpu_din, vq[i].cdin);
      end
      chk({vq[i].name, "_buf_we"}, {28'h0, buf_we}, {28'h0, vq[i].bwe});
      if (vq[i].bwe != 4'h0) begin
        chk({vq[i].name, "_buf_addr"}, {11'h0, buf_addr}, {11'h0, vq[i].baddr});
        chk({vq[i].name, "_buf_din"}, buf_din, vq[i].bdin);
      end
      chk({vq[i].name, "_out_reg"}, out_reg, vq[i].oreg);
      chk({vq[i].name, "_fault"}, {31'h0, st_fault}, {31'h0, vq[i].drop & fault_en});
      chk({vq[i].name, "_empty"}, {31'h0, st_empty}, 32'h0);
    end

    // Strobes last one cycle; st_empty returns the cycle after the last write.
    @(posedge clk);
    #1;
    chk("idle_cpu_we", {28'h0, cpu_we}, 32'h0);
    chk("idle_buf_we", {28'h0, buf_we}, 32'h0);
    chk("idle_empty", {31'h0, st_empty}, 32'h1);
    chk("idle_fault", {31'h0, st_fault}, 32'h0);
    exp_faddr = fault_en ? 32'h0200_0104 : 32'h0;
    chk("fault_addr", fault_addr, exp_faddr);

    // Buffer backpressure: five offered, four fit, then drained in order.
    @(negedge clk);
    buf_wr_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      st_valid = 1'b1; st_addr = 32'h0100_0000 + 32'(4 * i);
      st_data = 32'h1000_0000 + 32'(i); st_size = 2'd2;
      if (st_ready) acc++;
      @(posedge clk);
      #1;
      chk($sformatf("bp_hold_we%0d", i), {28'h0, buf_we}, 32'h0);
    end
    @(negedge clk);
    st_valid = 1'b0;
    chk("bp_accepted", 32'(acc), 32'd4);
    chk("bp_ready", {31'h0, st_ready}, 32'h0);
    chk("bp_empty", {31'h0, st_empty}, 32'h0);
    buf_wr_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("bp_we%0d", i), {28'h0, buf_we}, 32'hF);
      chk($sformatf("bp_addr%0d", i), {11'h0, buf_addr}, 32'(i));
      chk($sformatf("bp_din%0d", i), buf_din, (32'(i) << 24) | 32'h10);
    end
    @(posedge clk);
    #1;
    chk("bp_done_we", {28'h0, buf_we}, 32'h0);
    chk("bp_done_empty", {31'h0, st_empty}, 32'h1);
    chk("bp_done_ready", {31'h0, st_ready}, 32'h1);

    // Reset with three stalled stores: they must vanish without a strobe.
    @(negedge clk);
    buf_wr_ready = 1'b0;
    for (int i = 0; i < 3; i++) push_one(32'h0100_0040 + 32'(4 * i), 32'h5555_0000 + 32'(i), 2'd2);
    @(negedge clk);
    chk("pre_rst_empty", {31'h0, st_empty}, 32'h0);
    reset = 1'b1;
    buf_wr_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_empty", {31'h0, st_empty}, 32'h1);
    chk("mid_rst_ready", {31'h0, st_ready}, 32'h1);
    chk("mid_rst_buf_we", {28'h0, buf_we}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("post_rst_buf_we%0d", i), {28'h0, buf_we}, 32'h0);
    end
    chk("post_rst_out_reg", out_reg, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
